kmp_prefix_table: RTL and testbench

KMP_PREFIX_TABLE -- requirements
Module: kmp_prefix_table

---
 rtl/kmp_pkg.sv | 20 ++
 rtl/kmp_pattern_buffer.sv | 36 +++
 rtl/kmp_prefix_table.sv | 151 +++++++++++++++
 tb/tb_kmp_prefix_table.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/kmp_pkg.sv
// Shared definitions for the KMP prefix-table builder and the matcher FSM.
package kmp_pkg;

   localparam int KMP_MAX_LEN = 8;   // maximum pattern length in characters
   localparam int KMP_CHAR_W  = 8;   // character width in bits
   localparam int KMP_ADDR_W  = 3;   // pattern / table address width

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_LOAD    = 2'd1,
      ST_COMPUTE = 2'd2,
      ST_DONE    = 2'd3
   } kmp_state_t;

   // A pattern length is usable when it is at least one and no longer than the buffer.
   function automatic logic len_legal(input logic [3:0] len, input logic [3:0] max_len);
      return (len != 4'd0) && (len <= max_len);
   endfunction

endpackage

// File: rtl/kmp_pattern_buffer.sv
// Pattern register file: one write port, two combinational read ports
// (one addressed by the scan index i, one by the current prefix length).
module kmp_pattern_buffer
   import kmp_pkg::*;
#(
   parameter int DEPTH = KMP_MAX_LEN,
   parameter int WIDTH = KMP_CHAR_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we,
   input  logic [KMP_ADDR_W-1:0] waddr,
   input  logic [WIDTH-1:0]      wdata,
   input  logic [KMP_ADDR_W-1:0] raddr_a,
   output logic [WIDTH-1:0]      rdata_a,
   input  logic [KMP_ADDR_W-1:0] raddr_b,
   output logic [WIDTH-1:0]      rdata_b
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Clear on reset, otherwise store one character per write strobe.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < DEPTH; k++) begin
            mem[k] <= {WIDTH{1'b0}};
         end
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata_a = mem[raddr_a];
   assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/kmp_prefix_table.sv
// Builds the KMP longest-proper-prefix-suffix table for a pattern fetched
// from a synchronous ROM: LOAD copies the pattern into a local buffer, then
// COMPUTE runs one step of the classic prefix-function loop per cycle.
module kmp_prefix_table
   import kmp_pkg::*;
#(
   parameter int MAX_LEN = KMP_MAX_LEN,
   parameter int CHAR_W  = KMP_CHAR_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [3:0]            pat_len,
   output logic [KMP_ADDR_W-1:0] rom_addr,
   input  logic [CHAR_W-1:0]     rom_data,
   input  logic [KMP_ADDR_W-1:0] lps_addr,
   output logic [KMP_ADDR_W-1:0] lps_data,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   localparam logic [3:0] MAX_LEN_W = 4'(MAX_LEN);

   kmp_state_t            state;
   logic [3:0]            m;        // latched pattern length
   logic [3:0]            ld_cnt;   // LOAD cycle counter, 0..m
   logic [KMP_ADDR_W-1:0] len;      // current matched prefix length
   logic [KMP_ADDR_W-1:0] i;        // scan index
   logic                  fin;      // i has reached m (i itself is only 3 bits)
   logic [KMP_ADDR_W-1:0] lps [MAX_LEN];

   logic                  buf_we;
   logic [KMP_ADDR_W-1:0] buf_waddr;
   logic [CHAR_W-1:0]     buf_i;
   logic [CHAR_W-1:0]     buf_len;
   logic                  i_last;

   // Pattern buffer: written from rom_data during LOAD, read at i and len during COMPUTE.
   kmp_pattern_buffer #(
      .DEPTH (MAX_LEN),
      .WIDTH (CHAR_W)
   ) u_buf (
      .clk     (clk),
      .rst     (rst),
      .we      (buf_we),
      .waddr   (buf_waddr),
      .wdata   (rom_data),
      .raddr_a (i),
      .rdata_a (buf_i),
      .raddr_b (len),
      .rdata_b (buf_len)
   );

   // ROM data arrives one cycle after its address, so LOAD cycle k writes buf[k-1].
   always_comb begin
      buf_we    = 1'b0;
      buf_waddr = 3'd0;
      if ((state == ST_LOAD) && (ld_cnt != 4'd0)) begin
         buf_we    = 1'b1;
         buf_waddr = ld_cnt[2:0] - 3'd1;
      end else begin
         buf_we    = 1'b0;
         buf_waddr = 3'd0;
      end
   end

   // Terminal compare of the 3-bit index against the 4-bit length.
   assign i_last   = (({1'b0, i} + 4'd1) == m);
   assign lps_data = lps[lps_addr];

   // Control FSM with registered outputs and the inline lps table.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         m        <= 4'd0;
         ld_cnt   <= 4'd0;
         len      <= 3'd0;
         i        <= 3'd0;
         fin      <= 1'b0;
         rom_addr <= 3'd0;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
         for (int k = 0; k < MAX_LEN; k++) begin
            lps[k] <= 3'd0;
         end
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  if (len_legal(pat_len, MAX_LEN_W)) begin
                     m        <= pat_len;
                     ld_cnt   <= 4'd0;
                     rom_addr <= 3'd0;
                     busy     <= 1'b1;
                     state    <= ST_LOAD;
                     // Clearing now leaves entries beyond m at zero after the build.
                     for (int k = 0; k < MAX_LEN; k++) begin
                        lps[k] <= 3'd0;
                     end
                  end else begin
                     err <= 1'b1;
                  end
               end
            end
            ST_LOAD: begin
               if (ld_cnt == m) begin
                  state    <= ST_COMPUTE;
                  rom_addr <= 3'd0;
                  lps[0]   <= 3'd0;
                  len      <= 3'd0;
                  i        <= 3'd1;
                  fin      <= (m == 4'd1);
               end else begin
                  ld_cnt   <= ld_cnt + 4'd1;
                  rom_addr <= rom_addr + 3'd1;
               end
            end
            ST_COMPUTE: begin
               if (fin) begin
                  state <= ST_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else if (buf_i == buf_len) begin
                  lps[i] <= len + 3'd1;
                  len    <= len + 3'd1;
                  i      <= i + 3'd1;
                  fin    <= i_last;
               end else if (len != 3'd0) begin
                  len <= lps[len - 3'd1];
               end else begin
                  lps[i] <= 3'd0;
                  i      <= i + 3'd1;
                  fin    <= i_last;
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_kmp_prefix_table.sv
// Directed bench for kmp_prefix_table with a synchronous pattern ROM model.
module tb_kmp_prefix_table;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [3:0] pat_len;
   logic [2:0] rom_addr;
   logic [7:0] rom_data;
   logic [2:0] lps_addr;
   logic [2:0] lps_data;
   logic       busy;
   logic       done;
   logic       err;

   logic [7:0] rom [8];
   int errors = 0;
   int checks = 0;

   kmp_prefix_table dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .pat_len  (pat_len),
      .rom_addr (rom_addr),
      .rom_data (rom_data),
      .lps_addr (lps_addr),
      .lps_data (lps_data),
      .busy     (busy),
      .done     (done),
      .err      (err)
   );

   always #5 clk = ~clk;

   // Synchronous ROM: data one cycle after the address.
   always @(posedge clk) rom_data <= rom[rom_addr];

   task automatic load_rom(input string s);
      for (int k = 0; k < 8; k++) rom[k] = (k < s.len()) ? s[k] : 8'h5A;
   endtask

   // Pulse start and observe 40 cycles; optional extra start at cycle 'inject'.
   task automatic run_build(input logic [3:0] len, input int inject,
                            output int busy_cyc, output int done_at, output int done_cnt,
                            output int err_cnt, output int rom_bad);
      busy_cyc = 0; done_at = -1; done_cnt = 0; err_cnt = 0; rom_bad = 0;
      @(posedge clk); #1; start = 1'b1; pat_len = len;
      @(posedge clk); #1; start = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (busy) busy_cyc++;
         if (done) begin done_cnt++; if (done_at < 0) done_at = k; end
         if (err) err_cnt++;
         if (k < int'(len) && rom_addr !== 3'(k)) rom_bad++;
         start = (k == inject);
         @(posedge clk); #1;
      end
      start = 1'b0;
   endtask

   task automatic test_reset;
      logic [2:0] want [8];
      want = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
      rst = 1'b1; start = 1'b1; pat_len = 4'd4;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
      checks++; if (rom_addr !== 3'd0) begin errors++; $display("FAIL reset_rom_addr: got %0d want 0", rom_addr); end
      start = 1'b0; rst = 1'b0;
      for (int k = 0; k < 8; k++) begin
         lps_addr = 3'(k); #1;
         checks++; if (lps_data !== want[k]) begin errors++; $display("FAIL reset_lps[%0d]: got %0d want %0d", k, lps_data, want[k]); end
      end
   endtask

   task automatic test_abab;
      int bc, da, dc, ec, rb;
      logic [2:0] want [8];
      want = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd0, 3'd0, 3'd0, 3'd0};
      load_rom("ABAB");
      run_build(4'd4, -1, bc, da, dc, ec, rb);
      checks++; if (dc != 1) begin errors++; $display("FAIL abab_done_pulses: got %0d want 1", dc); end
      checks++; if (bc < 6 || bc > 12) begin errors++; $display("FAIL abab_busy_cycles: got %0d want 6..12", bc); end
      checks++; if (da != bc) begin errors++; $display("FAIL abab_done_after_busy: got %0d want %0d", da, bc); end
      checks++; if (rb != 0) begin errors++; $display("FAIL abab_rom_addr_seq: got %0d bad want 0", rb); end
      checks++; if (ec != 0) begin errors++; $display("FAIL abab_err: got %0d want 0", ec); end
      for (int k = 0; k < 8; k++) begin
         lps_addr = 3'(k); #1;
         checks++; if (lps_data !== want[k]) begin errors++; $display("FAIL abab_lps[%0d]: got %0d want %0d", k, lps_data, want[k]); end
      end
   endtask

   task automatic test_long;
      int bc, da, dc, ec, rb;
      logic [2:0] want [8];
      want = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd1, 3'd2, 3'd3, 3'd3};
      load_rom("AAACAAAA");
      run_build(4'd8, -1, bc, da, dc, ec, rb);
      checks++; if (dc != 1) begin errors++; $display("FAIL long_done_pulses: got %0d want 1", dc); end
      checks++; if (bc - 9 < 1 || bc - 9 > 15) begin errors++; $display("FAIL long_compute_cycles: got %0d want 1..15", bc - 9); end
      checks++; if (rb != 0) begin errors++; $display("FAIL long_rom_addr_seq: got %0d bad want 0", rb); end
      for (int k = 0; k < 8; k++) begin
         lps_addr = 3'(k); #1;
         checks++; if (lps_data !== want[k]) begin errors++; $display("FAIL long_lps[%0d]: got %0d want %0d", k, lps_data, want[k]); end
      end
   endtask

   task automatic test_reject;
      logic [3:0] bad [2];
      logic [2:0] want [8];
      bad  = '{4'd0, 4'd9};
      want = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd1, 3'd2, 3'd3, 3'd3};
      for (int n = 0; n < 2; n++) begin
         @(posedge clk); #1; start = 1'b1; pat_len = bad[n];
         @(posedge clk); #1; start = 1'b0;
         checks++; if (err !== 1'b1) begin errors++; $display("FAIL reject%0d_err_pulse: got %b want 1", bad[n], err); end
         checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reject%0d_busy: got %b want 0", bad[n], busy); end
         @(posedge clk); #1;
         checks++; if (err !== 1'b0) begin errors++; $display("FAIL reject%0d_err_clear: got %b want 0", bad[n], err); end
         checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reject%0d_busy_after: got %b want 0", bad[n], busy); end
      end
      for (int k = 0; k < 8; k++) begin
         lps_addr = 3'(k); #1;
         checks++; if (lps_data !== want[k]) begin errors++; $display("FAIL reject_lps[%0d]: got %0d want %0d", k, lps_data, want[k]); end
      end
   endtask

   task automatic test_reset_mid_load;
      int dc;
      load_rom("AABA");
      @(posedge clk); #1; start = 1'b1; pat_len = 4'd4;
      @(posedge clk); #1; start = 1'b0;          // LOAD cycle 1
      @(posedge clk); #1;                        // LOAD cycle 2
      @(posedge clk); #1; rst = 1'b1;            // LOAD cycle 3
      @(posedge clk); #1; rst = 1'b0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
      checks++; if (rom_addr !== 3'd0) begin errors++; $display("FAIL midrst_rom_addr: got %0d want 0", rom_addr); end
      for (int k = 0; k < 8; k++) begin
         lps_addr = 3'(k); #1;
         checks++; if (lps_data !== 3'd0) begin errors++; $display("FAIL midrst_lps[%0d]: got %0d want 0", k, lps_data); end
      end
      dc = 0;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk); #1;
         if (done || busy) dc++;
      end
      checks++; if (dc != 0) begin errors++; $display("FAIL midrst_idle: got %0d active cycles want 0", dc); end
   endtask

   task automatic test_aaba;
      int bc, da, dc, ec, rb;
      logic [2:0] want [8];
      want = '{3'd0, 3'd1, 3'd0, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0};
      load_rom("AABA");
      run_build(4'd4, -1, bc, da, dc, ec, rb);
      checks++; if (dc != 1) begin errors++; $display("FAIL aaba_done_pulses: got %0d want 1", dc); end
      for (int k = 0; k < 8; k++) begin
         lps_addr = 3'(k); #1;
         checks++; if (lps_data !== want[k]) begin errors++; $display("FAIL aaba_lps[%0d]: got %0d want %0d", k, lps_data, want[k]); end
      end
   endtask

   task automatic test_single;
      int bc, da, dc, ec, rb;
      load_rom("A");
      run_build(4'd1, -1, bc, da, dc, ec, rb);
      checks++; if (da != 3) begin errors++; $display("FAIL single_done_latency: got %0d want 3", da); end
      checks++; if (dc != 1) begin errors++; $display("FAIL single_done_pulses: got %0d want 1", dc); end
      for (int k = 0; k < 8; k++) begin
         lps_addr = 3'(k); #1;
         checks++; if (lps_data !== 3'd0) begin errors++; $display("FAIL single_lps[%0d]: got %0d want 0", k, lps_data); end
      end
   endtask

   task automatic test_abcd;
      int bc, da, dc, ec, rb;
      load_rom("ABCD");
      run_build(4'd4, -1, bc, da, dc, ec, rb);
      checks++; if (dc != 1) begin errors++; $display("FAIL abcd_done_pulses: got %0d want 1", dc); end
      checks++; if (bc - 5 < 1 || bc - 5 > 7) begin errors++; $display("FAIL abcd_compute_cycles: got %0d want 1..7", bc - 5); end
      for (int k = 0; k < 8; k++) begin
         lps_addr = 3'(k); #1;
         checks++; if (lps_data !== 3'd0) begin errors++; $display("FAIL abcd_lps[%0d]: got %0d want 0", k, lps_data); end
      end
   endtask

   task automatic test_back_to_back;
      int bc, da, dc, ec, rb;
      logic [2:0] want [8];
      want = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0};
      load_rom("ABAA");
      pat_len = 4'd4;
      run_build(4'd4, 6, bc, da, dc, ec, rb);   // extra start lands in COMPUTE
      checks++; if (ec != 0) begin errors++; $display("FAIL b2b_err: got %0d want 0", ec); end
      checks++; if (dc != 1) begin errors++; $display("FAIL b2b_done_pulses: got %0d want 1", dc); end
      for (int k = 0; k < 8; k++) begin
         lps_addr = 3'(k); #1;
         checks++; if (lps_data !== want[k]) begin errors++; $display("FAIL b2b_lps[%0d]: got %0d want %0d", k, lps_data, want[k]); end
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; pat_len = 4'd0; lps_addr = 3'd0;
      for (int k = 0; k < 8; k++) rom[k] = 8'h00;
      test_reset;
      test_abab;
      test_long;
      test_reject;
      test_reset_mid_load;
      test_aaba;
      test_single;
      test_abcd;
      test_back_to_back;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
